// File: rtl/sdram_aref.sv
// Auto-refresh generator: periodic refresh request, then PRECHARGE-ALL + AREF_NUM AUTO REFRESH on grant.
// Optional SDRAM_AREF_MISS_EN adds aref_miss, a pulse when an interval wraps with the request still pending.
module sdram_aref #(
  parameter int CNT_REF_MAX = 749,
  parameter int TRP_CLK     = 2,
  parameter int TRFC_CLK    = 7,
  parameter int AREF_NUM    = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_ba,
  output logic [12:0] aref_addr,
  output logic        aref_end
`ifdef SDRAM_AREF_MISS_EN
  ,
  output logic        aref_miss
`endif
);

  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;

  localparam int REF_W     = $clog2(CNT_REF_MAX + 1);
  localparam int DWELL_MAX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
  localparam int CLK_W     = $clog2(DWELL_MAX + 1);
  localparam int NUM_W     = $clog2(AREF_NUM + 1);

  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(CNT_REF_MAX);
  localparam logic [CLK_W-1:0] TRP_LAST  = CLK_W'(TRP_CLK - 1);
  localparam logic [CLK_W-1:0] TRFC_LAST = CLK_W'(TRFC_CLK - 1);
  localparam logic [NUM_W-1:0] NUM_LIM   = NUM_W'(AREF_NUM);

  typedef enum logic [2:0] {
    AREF_IDLE,
    AREF_PCHA,
    AREF_TRP,
    AUTO_REF,
    AREF_TRF,
    AREF_END
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [REF_W-1:0]  cnt_ref;
  logic [CLK_W-1:0]  cnt_clk;
  logic [NUM_W-1:0]  cnt_aref;
  logic              ref_wrap;

  assign ref_wrap = init_end && (cnt_ref == REF_LAST);

  // Refresh interval timer keeps running through an operation so the cadence never drifts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_ref <= '0;
    end else if (!init_end || cnt_ref == REF_LAST) begin
      cnt_ref <= '0;
    end else begin
      cnt_ref <= cnt_ref + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aref_req <= 1'b0;
    end else if (!init_end) begin
      aref_req <= 1'b0;
    end else if (ref_wrap) begin
      aref_req <= 1'b1;
    end else if (state == AREF_PCHA) begin
      aref_req <= 1'b0;
    end
  end

`ifdef SDRAM_AREF_MISS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aref_miss <= 1'b0;
    end else begin
      aref_miss <= ref_wrap && aref_req;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= AREF_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      AREF_IDLE: if (aref_en && aref_req && init_end) next_state = AREF_PCHA;
      AREF_PCHA: next_state = AREF_TRP;
      AREF_TRP:  if (cnt_clk == TRP_LAST) next_state = AUTO_REF;
      AUTO_REF:  next_state = AREF_TRF;
      AREF_TRF: begin
        if (cnt_clk == TRFC_LAST) begin
          next_state = (cnt_aref < NUM_LIM) ? AUTO_REF : AREF_END;
        end
      end
      AREF_END:  next_state = AREF_IDLE;
      default:   next_state = AREF_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_clk <= '0;
    end else if (state != next_state) begin
      cnt_clk <= '0;
    end else begin
      cnt_clk <= cnt_clk + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_aref <= '0;
    end else if (state == AUTO_REF) begin
      cnt_aref <= cnt_aref + 1'b1;
    end else if (state == AREF_END) begin
      cnt_aref <= '0;
    end
  end

  always_comb begin
    aref_cmd = CMD_NOP;
    aref_end = 1'b0;
    case (state)
      AREF_PCHA: aref_cmd = CMD_PRECHARGE;
      AUTO_REF:  aref_cmd = CMD_AUTO_REFRESH;
      AREF_END:  aref_end = 1'b1;
      default:   aref_cmd = CMD_NOP;
    endcase
  end

  // A10 high makes the PRECHARGE apply to all banks.
  assign aref_ba   = 2'b11;
  assign aref_addr = 13'h1FFF;

endmodule

// File: tb/tb_sdram_aref.sv
// Directed self-checking bench for sdram_aref: reset, first request, command stream, spurious grant, reset mid-op.
module tb_sdram_aref;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        init_end;
  logic        aref_en;
  logic        aref_req;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic        aref_end;
`ifdef SDRAM_AREF_MISS_EN
  logic        aref_miss;
`endif

  int n_cmp;
  int n_fail;
  int cyc;
  int t_init;
  int t_g;
  int t_rel;
  logic [3:0] exp_cmd [1:21];

  sdram_aref dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end),
    .aref_en   (aref_en),
    .aref_req  (aref_req),
    .aref_cmd  (aref_cmd),
    .aref_ba   (aref_ba),
    .aref_addr (aref_addr),
    .aref_end  (aref_end)
`ifdef SDRAM_AREF_MISS_EN
    ,
    .aref_miss (aref_miss)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_cmd"},  32'(aref_cmd),  32'h7);
    check({tag, "_end"},  32'(aref_end),  32'h0);
    check({tag, "_ba"},   32'(aref_ba),   32'h3);
    check({tag, "_addr"}, 32'(aref_addr), 32'h1FFF);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    for (int k = 1; k <= 21; k++) exp_cmd[k] = 4'b0111;
    exp_cmd[1]  = 4'b0010;
    exp_cmd[4]  = 4'b0001;
    exp_cmd[12] = 4'b0001;

    sys_rst_n = 1'b0;
    init_end  = 1'b0;
    aref_en   = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check_idle_pins("rst");
    check("rst_req", 32'(aref_req), 32'h0);
    check("rst_cnt_ref", 32'(dut.cnt_ref), 32'h0);

    // Released but not yet initialised: nothing may move.
    sys_rst_n = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      step();
      check("pre_init_cmd", 32'(aref_cmd), 32'h7);
      check("pre_init_req", 32'(aref_req), 32'h0);
      check("pre_init_end", 32'(aref_end), 32'h0);
      check("pre_init_cnt_ref", 32'(dut.cnt_ref), 32'h0);
    end

    init_end = 1'b1;
    t_init = cyc;
    while (cyc < t_init + 749) step();
    check("req_before_750", 32'(aref_req), 32'h0);
    check("cnt_ref_749", 32'(dut.cnt_ref), 32'd749);
    step();
    check("req_at_750", 32'(aref_req), 32'h1);
    check("cnt_ref_wrap", 32'(dut.cnt_ref), 32'h0);

    for (int k = 0; k < 200; k++) begin
      step();
      check("req_held", 32'(aref_req), 32'h1);
      check("held_cmd", 32'(aref_cmd), 32'h7);
    end

    // Single-cycle grant at G, stream checked G+1..G+21.
    aref_en = 1'b1;
    t_g = cyc;
    check("grant_req", 32'(aref_req), 32'h1);
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 1) aref_en = 1'b0;
      check("seq_cmd", 32'(aref_cmd), 32'(exp_cmd[k]));
      check("seq_end", 32'(aref_end), (k == 20) ? 32'h1 : 32'h0);
      check("seq_ba", 32'(aref_ba), 32'h3);
      check("seq_addr", 32'(aref_addr), 32'h1FFF);
      if (k >= 2) check("seq_req", 32'(aref_req), 32'h0);
    end

    aref_en = 1'b1;
    step();
    aref_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("spurious_cmd", 32'(aref_cmd), 32'h7);
      check("spurious_req", 32'(aref_req), 32'h0);
    end

    while (cyc < t_init + 1499) step();
    check("req_before_1500", 32'(aref_req), 32'h0);
    step();
    check("req_at_1500", 32'(aref_req), 32'h1);

    aref_en = 1'b1;
    t_g = cyc;
    step();
    aref_en = 1'b0;
    check("op2_pcha", 32'(aref_cmd), 32'h2);
    while (cyc < t_g + 4) step();
    check("op2_aref", 32'(aref_cmd), 32'h1);
    while (cyc < t_g + 7) step();
    check("op2_trf_cmd", 32'(aref_cmd), 32'h7);

    sys_rst_n = 1'b0;
    #1;
    check_idle_pins("midrst");
    check("midrst_req", 32'(aref_req), 32'h0);
    check("midrst_cnt_ref", 32'(dut.cnt_ref), 32'h0);
    step();
    step();
    check_idle_pins("midrst_hold");

    // init_end stays high, so the interval restarts from the release cycle.
    sys_rst_n = 1'b1;
    t_rel = cyc;
    while (cyc < t_rel + 749) begin
      step();
      check("post_rst_cmd", 32'(aref_cmd), 32'h7);
      check("post_rst_end", 32'(aref_end), 32'h0);
    end
    check("post_rst_req_749", 32'(aref_req), 32'h0);
    step();
    check("post_rst_req_750", 32'(aref_req), 32'h1);

`ifdef SDRAM_AREF_MISS_EN
    check("miss_first_wrap", 32'(aref_miss), 32'h0);
    while (cyc < t_rel + 1499) step();
    check("miss_before", 32'(aref_miss), 32'h0);
    step();
    check("miss_pulse", 32'(aref_miss), 32'h1);
    check("miss_req", 32'(aref_req), 32'h1);
    step();
    check("miss_after", 32'(aref_miss), 32'h0);
    check("miss_req_after", 32'(aref_req), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
